// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels and the baud divider calculation.
// Used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clocks per bit, truncating; callers reject results below 2.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1, flags the last and next-to-last cycle of each bit.
// restart holds the count at zero so the next bit period starts cleanly.
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || bit_end) begin
            // NOTE: non-blocking assignments on registered state so every flop samples pre-edge values.
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end     = (cnt == CNT_LAST);
    assign bit_pre_end = (cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops bytes from an FWFT FIFO and sends start, data (LSB first), stop bits.
// Optional parity bit when UART_TX_PARITY_EN is defined (sense set by PARITY_ODD).
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    import uart_pkg::*;

    localparam int DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int BIT_CNT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_parity_check
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    uart_state_t            state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   tx_d, busy_d, rd_en_d, done_d;
    logic                   load_now;
    logic                   last_stop;
    logic                   bit_end, bit_pre_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // The divider is parked at zero while idle so the start bit gets a full period.
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk         (clk),
        .reset_n     (reset_n),
        .restart     (state_q == IDLE),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    assign last_stop = (STOP_BITS == 1) || stop_idx_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q_hold();
        busy_d     = busy;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        load_now   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d     = IDLE_LEVEL;
                busy_d   = 1'b0;
                load_now = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = BIT_CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
                        tx_d       = parity_q;
`else
                        state_d    = STOP;
                        tx_d       = IDLE_LEVEL;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    tx_d       = IDLE_LEVEL;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                // Registered pulse: raised one cycle early so it lands in the final stop cycle.
                done_d = last_stop && bit_pre_end;
                if (bit_end) begin
                    if (!last_stop) begin
                        stop_idx_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load_now = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = IDLE_LEVEL;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase

        if (load_now) begin
            state_d = START;
            shift_d = fifo_data;
            rd_en_d = 1'b1;
            tx_d    = START_LEVEL;
            busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
        end
    end

    function automatic logic tx_q_hold();
        return tx;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_idx_q <= 1'b0;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_idx_q <= stop_idx_d;
            tx         <= tx_d;
            busy       <= busy_d;
            fifo_rd_en <= rd_en_d;
            tx_done    <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule
